// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver presenting each byte on an AXI4-Stream master port; bit time = prescale*8 clk.
// Optional UART_RX_FILTER_EN adds a 3-tap majority filter after the input synchroniser.
module uart_rx_axis (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        rxd,
    output logic        busy,
    output logic        overrun_error,
    output logic        frame_error,
    input  logic [15:0] prescale
);
    // state     | meaning
    // IDLE      | line idle, waiting for a falling edge
    // START     | timing to the middle of the start bit
    // DATA      | sampling 8 data bits at their centres, LSB first
    // STOP      | sampling the stop bit, committing or flagging the byte
    // WAIT_HIGH | framing error or break, waiting for the line to return high
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state, state_nxt;
    logic        rxd_m, rxd_s, rx;
    logic [18:0] timer, timer_nxt, bit_time, half_time;
    logic [15:0] prescale_lat, prescale_lat_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift, shift_nxt, tdata_nxt;
    logic        tvalid_nxt, ovr_nxt, fe_nxt;
    logic        timer_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_FILTER_EN
    logic [1:0] rxd_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxd_hist <= 2'b11;
        else        rxd_hist <= {rxd_hist[0], rxd_s};
    end

    // median of the last three samples: a single-cycle low never reaches the FSM
    assign rx = (rxd_s & rxd_hist[0]) | (rxd_s & rxd_hist[1]) | (rxd_hist[0] & rxd_hist[1]);
`else
    assign rx = rxd_s;
`endif

    assign bit_time  = {prescale_lat, 3'b000} - 19'd1;
    assign half_time = {1'b0, prescale, 2'b00} - 19'd1;
    assign timer_tc  = (timer == 19'd0);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt        = state;
        timer_nxt        = timer;
        prescale_lat_nxt = prescale_lat;
        bit_cnt_nxt      = bit_cnt;
        shift_nxt        = shift;
        tdata_nxt        = m_axis_tdata;
        tvalid_nxt       = m_axis_tvalid;
        ovr_nxt          = 1'b0;
        fe_nxt           = 1'b0;
        if (m_axis_tvalid && m_axis_tready) tvalid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!rx && prescale != 16'd0) begin
                    prescale_lat_nxt = prescale;
                    timer_nxt        = half_time;
                    state_nxt        = START;
                end
            end
            START: begin
                if (!timer_tc) begin
                    timer_nxt = timer - 19'd1;
                end else if (!rx) begin
                    timer_nxt   = bit_time;
                    bit_cnt_nxt = 4'd8;
                    state_nxt   = DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!timer_tc) begin
                    timer_nxt = timer - 19'd1;
                end else begin
                    shift_nxt   = {rx, shift[7:1]};
                    bit_cnt_nxt = bit_cnt - 4'd1;
                    timer_nxt   = bit_time;
                    if (bit_cnt == 4'd1) state_nxt = STOP;
                end
            end
            STOP: begin
                if (!timer_tc) begin
                    timer_nxt = timer - 19'd1;
                end else if (rx) begin
                    // an unconsumed byte is overwritten unless it leaves on this same edge
                    tdata_nxt  = shift;
                    tvalid_nxt = 1'b1;
                    ovr_nxt    = m_axis_tvalid && !m_axis_tready;
                    state_nxt  = IDLE;
                end else begin
                    fe_nxt    = 1'b1;
                    state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= 19'd0;
            prescale_lat  <= 16'd0;
            bit_cnt       <= 4'd0;
            shift         <= 8'd0;
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            prescale_lat  <= prescale_lat_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shift         <= shift_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tvalid <= tvalid_nxt;
            overrun_error <= ovr_nxt;
            frame_error   <= fe_nxt;
        end
    end
endmodule

// File: tb/tb_uart_rx_axis.sv
// Randomised bench for uart_rx_axis: frames are scheduled as timed commit events and an output
// holding-register model is compared against the DUT every cycle, plus literal spot checks.
module tb_uart_rx_axis;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic [15:0] prescale;

    uart_rx_axis dut (
        .clk(clk), .rst_n(rst_n),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .rxd(rxd), .busy(busy), .overrun_error(overrun_error), .frame_error(frame_error),
        .prescale(prescale)
    );

    always #5 clk = ~clk;

    // cycles from the edge that launches the falling rxd edge to the start-detect edge
`ifdef UART_RX_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int         cyc;
        bit         ferr;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] xlog[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ovr_cnt = 0;
    int         fe_cnt = 0;
    bit         chk_en = 1'b0;
    bit         rnd_done = 1'b0;
    logic       tready_q = 1'b0;
    bit         mv = 1'b0;
    logic [7:0] md = 8'd0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        tready_q <= m_axis_tready;
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) xlog.push_back(m_axis_tdata);
            if (overrun_error) ovr_cnt++;
            if (frame_error) fe_cnt++;
        end
    end

    // Output model: one holding register fed by scheduled commit events, drained by handshakes.
    always @(negedge clk) begin
        bit   xfer, mv_b, ovr_e, fe_e;
        ev_t  ev;
        if (!rst_n) begin
            mv = 1'b0;
            md = 8'd0;
        end else if (chk_en) begin
            mv_b  = mv;
            xfer  = mv && tready_q;
            ovr_e = 1'b0;
            fe_e  = 1'b0;
            if (xfer) mv = 1'b0;
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL event_missed: scheduled cycle %0d, now %0d", evq[0].cyc, cyc);
                ev = evq.pop_front();
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.ferr) begin
                    fe_e = 1'b1;
                end else begin
                    ovr_e = mv_b && !xfer;
                    md    = ev.d;
                    mv    = 1'b1;
                end
            end
            check("tvalid", int'(m_axis_tvalid), int'(mv));
            check("tdata", int'(m_axis_tdata), int'(md));
            check("overrun_error", int'(overrun_error), int'(ovr_e));
            check("frame_error", int'(frame_error), int'(fe_e));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame; cut < 10 stops after that many bit slots (no commit expected).
    task automatic send_frame(input logic [7:0] d, input int p, input logic stop_v,
                              input int stop_cycles, input int cut);
        logic [9:0] bits;
        int         len;
        ev_t        ev;
        bits = {stop_v, d, 1'b0};
        @(posedge clk);
        #1;
        prescale = 16'(p);
        rxd      = 1'b0;
        if (cut >= 10) begin
            ev.cyc  = cyc + LAT + 76 * p;
            ev.ferr = !stop_v;
            ev.d    = d;
            evq.push_back(ev);
        end
        for (int s = 0; s < 10 && s < cut; s++) begin
            len = (s == 9) ? stop_cycles : 8 * p;
            rxd = bits[s];
            for (int c = 0; c < len; c++) begin
                if (s == 0 && c == 6) prescale = 16'($urandom_range(1, 7));
                if (s == 5 && c == 0) check("busy_mid_frame", int'(busy), 1);
                @(posedge clk);
                #1;
            end
        end
        rxd = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, f0, o0, budget;
        int p, gap;
        logic [7:0] d;
        bit ferr;

        rst_n = 1'b0;
        rxd = 1'b1;
        m_axis_tready = 1'b1;
        prescale = 16'd1;
        idle(3);
        check("rst_tvalid", int'(m_axis_tvalid), 0);
        check("rst_tdata", int'(m_axis_tdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun_error), 0);
        check("rst_frame_error", int'(frame_error), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(5);

        // single byte at 8 clk/bit
        n0 = xlog.size();
        send_frame(8'h55, 1, 1'b1, 8, 10);
        idle(10);
        check("t1_count", xlog.size(), n0 + 1);
        check("t1_byte", int'(xlog[xlog.size() - 1]), 8'h55);
        check("t1_no_overrun", ovr_cnt, 0);
        check("t1_no_frame_error", fe_cnt, 0);
        check("t1_busy_after", int'(busy), 0);

        // back-to-back frames at 16 clk/bit
        n0 = xlog.size();
        send_frame(8'hA5, 2, 1'b1, 16, 10);
        send_frame(8'h3C, 2, 1'b1, 16, 10);
        idle(20);
        check("t2_count", xlog.size(), n0 + 2);
        check("t2_first", int'(xlog[n0]), 8'hA5);
        check("t2_second", int'(xlog[n0 + 1]), 8'h3C);

        // overrun while the consumer stalls
        m_axis_tready = 1'b0;
        n0 = xlog.size();
        send_frame(8'h11, 1, 1'b1, 8, 10);
        send_frame(8'h22, 1, 1'b1, 8, 10);
        idle(5);
        check("t3_overrun_pulses", ovr_cnt, 1);
        check("t3_tdata", int'(m_axis_tdata), 8'h22);
        check("t3_tvalid", int'(m_axis_tvalid), 1);
        m_axis_tready = 1'b1;
        idle(3);
        check("t3_count", xlog.size(), n0 + 1);
        check("t3_byte", int'(xlog[xlog.size() - 1]), 8'h22);
        check("t3_tvalid_cleared", int'(m_axis_tvalid), 0);

        // 2-clk low glitch: false start rejected at the start-bit centre
        n0 = xlog.size();
        @(posedge clk);
        #1;
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(3);
        check("t4_busy_during", int'(busy), 1);
        idle(10);
        check("t4_busy_after", int'(busy), 0);
        check("t4_no_byte", xlog.size(), n0);

        // stop bit held low for two bit times, then a good frame
        n0 = xlog.size();
        f0 = fe_cnt;
        send_frame(8'h7E, 1, 1'b0, 16, 10);
        idle(10);
        check("t5_frame_error_pulses", fe_cnt, f0 + 1);
        check("t5_no_byte", xlog.size(), n0);
        send_frame(8'h81, 1, 1'b1, 8, 10);
        idle(10);
        check("t5_recover_count", xlog.size(), n0 + 1);
        check("t5_recover_byte", int'(xlog[xlog.size() - 1]), 8'h81);

        // prescale 0 disables reception
        prescale = 16'd0;
        rxd = 1'b0;
        idle(40);
        check("t6_busy", int'(busy), 0);
        rxd = 1'b1;
        idle(10);

        // reset in the middle of a data bit
        m_axis_tready = 1'b0;
        send_frame(8'h5A, 4, 1'b1, 32, 10);
        idle(4);
        check("t7_pending_tvalid", int'(m_axis_tvalid), 1);
        send_frame(8'hF0, 4, 1'b1, 32, 5);
        rst_n = 1'b0;
        #1;
        check("t7_rst_tvalid", int'(m_axis_tvalid), 0);
        check("t7_rst_tdata", int'(m_axis_tdata), 0);
        check("t7_rst_busy", int'(busy), 0);
        rxd = 1'b1;
        idle(3);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        idle(5);
        n0 = xlog.size();
        send_frame(8'hC3, 4, 1'b1, 32, 10);
        idle(10);
        check("t7_count", xlog.size(), n0 + 1);
        check("t7_byte", int'(xlog[xlog.size() - 1]), 8'hC3);

        // randomised frames, gaps, framing errors and consumer stalls
        o0 = ovr_cnt;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    p    = $urandom_range(1, 3);
                    d    = 8'($urandom);
                    ferr = ($urandom_range(0, 7) == 0);
                    send_frame(d, p, !ferr, 8 * p, 10);
                    gap = ferr ? $urandom_range(8 * p, 16 * p) : $urandom_range(0, 16);
                    idle(gap);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    m_axis_tready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_axis_tready = 1'b1;
        budget = 2000;
        while ((evq.size() > 0 || m_axis_tvalid) && budget > 0) begin
            idle(1);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d events still pending", evq.size());
        end
        idle(5);
        check("end_events_pending", evq.size(), 0);
        check("end_busy", int'(busy), 0);
        check("end_tvalid", int'(m_axis_tvalid), 0);
        if (ovr_cnt < o0) check("overrun_count_monotonic", ovr_cnt, o0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
